// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the fetch-stage program counter and its neighbours
//   (fetch and branch units reuse the default width/step constants).
//   Contents:
//     PC_ADDR_W / PC_INC  default PC width and sequential step
//     pc_sel_e            next-PC source, listed in priority order
//     pc_priority()       priority encoder stall > load > call > ret > br > inc
//     sext()              sign-extends the low w bits of a value to 64 bits
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int PC_ADDR_W = 16;
    localparam int PC_INC    = 1;

    typedef enum logic [2:0] {
        PC_SEL_STALL = 3'd0,
        PC_SEL_LOAD  = 3'd1,
        PC_SEL_CALL  = 3'd2,
        PC_SEL_RET   = 3'd3,
        PC_SEL_BR    = 3'd4,
        PC_SEL_INC   = 3'd5
    } pc_sel_e;

    // Only the highest-priority request wins; the rest are dropped entirely,
    // which is what keeps push and pop from ever meeting in one cycle.
    function automatic pc_sel_e pc_priority(input logic stall,
                                            input logic load,
                                            input logic call,
                                            input logic ret,
                                            input logic br);
        if (stall)     return PC_SEL_STALL;
        else if (load) return PC_SEL_LOAD;
        else if (call) return PC_SEL_CALL;
        else if (ret)  return PC_SEL_RET;
        else if (br)   return PC_SEL_BR;
        else           return PC_SEL_INC;
    endfunction

    // Sign-extend the low w bits of val (1 <= w <= 64). Callers size-cast the
    // result down to their own PC width, so the function stays width-agnostic.
    function automatic logic [63:0] sext(input logic [63:0]   val,
                                         input int unsigned   w);
        logic [63:0] sign;
        logic [63:0] mask;
        sign = 64'(1) << (w - 1);
        mask = (sign << 1) - 64'(1);
        return ((val & mask) ^ sign) - sign;
    endfunction

endpackage

// File: rtl/prog_cntr_unit_if.sv
// ---------------------------------------------------------------------------
// prog_cntr_unit_if
//   Request/status bundle between decode/execute and the program counter.
//   master : drives redirect requests, observes PC and stack status
//   slave  : the program counter itself
//   Signals:
//     stall, wrPC, dataIn, br_en, br_off, call_en, ret_en   requests
//     cnt, cnt_next, stk_empty, stk_full, stk_err           status
// ---------------------------------------------------------------------------
interface prog_cntr_unit_if #(
    parameter int ADDR_W = pc_pkg::PC_ADDR_W,
    parameter int OFF_W  = 8
);
    logic              stall;
    logic              wrPC;
    logic [ADDR_W-1:0] dataIn;
    logic              br_en;
    logic [OFF_W-1:0]  br_off;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_err;

    modport master (
        output stall, wrPC, dataIn, br_en, br_off, call_en, ret_en,
        input  cnt, cnt_next, stk_empty, stk_full, stk_err
    );

    modport slave (
        input  stall, wrPC, dataIn, br_en, br_off, call_en, ret_en,
        output cnt, cnt_next, stk_empty, stk_full, stk_err
    );
endinterface

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
//   Circular return-address stack. A push while full overwrites the oldest
//   entry and keeps the occupancy saturated; a pop while empty is ignored.
//   dout is the current top (read-first), valid whenever empty=0.
//   Ports:
//     clk, rst     clock / asynchronous active-high reset
//     push, pop    never both high (caller's priority guarantees it)
//     din          address to push
//     dout         top-of-stack
//     empty, full  occupancy status (from registered state)
//     ovf, unf     single-cycle pulses: push while full / pop while empty
// ---------------------------------------------------------------------------
module ret_addr_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ret_addr_stack: DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] top_q;     // next free slot; wraps modulo DEPTH
    logic [CW-1:0] fill_q;    // occupancy, saturates at DEPTH

    assign empty = (fill_q == '0);
    assign full  = (fill_q == CW'(DEPTH));
    assign ovf   = push & full;
    assign unf   = pop & empty;
    assign dout  = mem[top_q - PW'(1)];

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q  <= '0;
            fill_q <= '0;
        end else if (push) begin
            // When full, slot top_q holds the oldest entry, so advancing the
            // pointer overwrites it and the window slides by one.
            top_q <= top_q + PW'(1);
            if (!full) fill_q <= fill_q + CW'(1);
        end else if (pop && !empty) begin
            top_q  <= top_q - PW'(1);
            fill_q <= fill_q - CW'(1);
        end
    end

    // NOTE: the storage array has no reset; only the pointers do. Contents are
    // never observed while empty, and leaving memories unreset lets them map
    // onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push) mem[top_q] <= din;
    end

endmodule

// File: rtl/prog_cntr_unit.sv
// ---------------------------------------------------------------------------
// prog_cntr_unit
//   Fetch-stage program counter: sequential increment, absolute load,
//   PC-relative branch, stall, and an optional call/return stack.
//   Priority per edge: stall > wrPC > call_en > ret_en > br_en > increment.
//   All PC arithmetic wraps modulo 2**ADDR_W without any flag.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset (cnt <= RST_VEC, stack cleared)
//     bus   prog_cntr_unit_if.slave: requests in, cnt/cnt_next/stk_* out
//   Build option:
//     CALL_STACK_EN  defined   -> ret_addr_stack instantiated, call pushes
//                               cnt+INC, ret pops (increment on empty).
//                    undefined -> no storage; call acts as wrPC, ret as a
//                               plain increment; stk_empty=1, stk_full=0,
//                               stk_err=0 constantly.
// ---------------------------------------------------------------------------
module prog_cntr_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W,
    parameter int                INC       = PC_INC,
    parameter int                OFF_W     = 8,
    parameter logic [ADDR_W-1:0] RST_VEC   = '0,
    parameter int                STK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    prog_cntr_unit_if.slave    bus
);
    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    if (STK_DEPTH < 2 || (STK_DEPTH & (STK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("prog_cntr_unit: STK_DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] off_ext;
    pc_sel_e           sel;

    assign sel     = pc_priority(bus.stall, bus.wrPC, bus.call_en,
                                 bus.ret_en, bus.br_en);
    assign off_ext = ADDR_W'(sext(64'(bus.br_off), OFF_W));

`ifdef CALL_STACK_EN
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_empty_w;
    logic              stk_full_w;
    logic              stk_ovf;
    logic              stk_unf;
    logic              stk_err_q;

    ret_addr_stack #(
        .DEPTH (STK_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (cnt_q + INC_V),
        .dout  (stk_top),
        .empty (stk_empty_w),
        .full  (stk_full_w),
        .ovf   (stk_ovf),
        .unf   (stk_unf)
    );

    // Stall selects nothing that touches the stack, so the sticky flag holds
    // through stalls automatically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    stk_err_q <= 1'b0;
        else if (stk_ovf | stk_unf) stk_err_q <= 1'b1;
    end

    assign bus.stk_empty = stk_empty_w;
    assign bus.stk_full  = stk_full_w;
    assign bus.stk_err   = stk_err_q;
`else
    assign bus.stk_empty = 1'b1;
    assign bus.stk_full  = 1'b0;
    assign bus.stk_err   = 1'b0;
`endif

    // Next-PC mux. cnt_d is also exported as cnt_next, so this is exactly the
    // value cnt takes at the coming edge.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
`ifdef CALL_STACK_EN
        stk_push = 1'b0;
        stk_pop  = 1'b0;
`endif
        unique case (sel)
            PC_SEL_STALL: cnt_d = cnt_q;
            PC_SEL_LOAD:  cnt_d = bus.dataIn;
            PC_SEL_CALL: begin
                cnt_d = bus.dataIn;
`ifdef CALL_STACK_EN
                stk_push = 1'b1;
`endif
            end
            PC_SEL_RET: begin
`ifdef CALL_STACK_EN
                // Pop is requested even when empty so the stack reports the
                // underflow; the PC then falls through to a plain increment.
                stk_pop = 1'b1;
                cnt_d   = stk_empty_w ? (cnt_q + INC_V) : stk_top;
`else
                cnt_d = cnt_q + INC_V;
`endif
            end
            PC_SEL_BR:    cnt_d = cnt_q + off_ext;
            default:      cnt_d = cnt_q + INC_V;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= RST_VEC;
        else     cnt_q <= cnt_d;
    end

    assign bus.cnt      = cnt_q;
    assign bus.cnt_next = cnt_d;

endmodule

// File: tb/tb_prog_cntr_unit.sv
// ---------------------------------------------------------------------------
// tb_prog_cntr_unit
//   Scoreboard bench for prog_cntr_unit. Each step drives one request at the
//   falling edge, advances a reference model, checks cnt_next, queues the
//   expected post-edge state, and pops/compares it just after the rising edge.
//   Call/return and overflow scenarios run when CALL_STACK_EN is defined; the
//   stackless behaviour is checked otherwise.
// ---------------------------------------------------------------------------
module tb_prog_cntr_unit;
    import pc_pkg::*;

    localparam int              AW      = 16;
    localparam int              OW      = 8;
    localparam int              INC     = 1;
    localparam int              DEPTH   = 8;
    localparam logic [AW-1:0]   RST_VEC = 16'h0000;
`ifdef CALL_STACK_EN
    localparam bit              STK_ON  = 1'b1;
`else
    localparam bit              STK_ON  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_cntr_unit_if #(.ADDR_W(AW), .OFF_W(OW)) bus ();

    prog_cntr_unit #(
        .ADDR_W    (AW),
        .INC       (INC),
        .OFF_W     (OW),
        .RST_VEC   (RST_VEC),
        .STK_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic          empty;
        logic          full;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk [$];
    logic          m_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = RST_VEC;
        m_err = 1'b0;
        m_stk.delete();
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cnt"},   32'(bus.cnt),       32'(RST_VEC));
        check({tag, "_empty"}, 32'(bus.stk_empty), 32'(1));
        check({tag, "_full"},  32'(bus.stk_full),  32'(0));
        check({tag, "_err"},   32'(bus.stk_err),   32'(0));
    endtask

    // One clock of stimulus; entered and left at a falling edge.
    task automatic step(input string tag, input logic st, input logic wr,
                        input logic [AW-1:0] din, input logic br,
                        input logic [OW-1:0] off, input logic cl,
                        input logic rt);
        logic [AW-1:0] nxt;
        exp_t          e;
        bus.stall   = st;
        bus.wrPC    = wr;
        bus.dataIn  = din;
        bus.br_en   = br;
        bus.br_off  = off;
        bus.call_en = cl;
        bus.ret_en  = rt;
        #1;
        nxt = m_pc;
        if (st) begin
            nxt = m_pc;
        end else if (wr) begin
            nxt = din;
        end else if (cl) begin
            if (STK_ON) begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    m_err = 1'b1;
                end
                m_stk.push_back(m_pc + AW'(INC));
            end
            nxt = din;
        end else if (rt) begin
            if (STK_ON && m_stk.size() > 0) begin
                nxt = m_stk.pop_back();
            end else begin
                nxt = m_pc + AW'(INC);
                if (STK_ON) m_err = 1'b1;
            end
        end else if (br) begin
            nxt = m_pc + AW'(signed'(off));
        end else begin
            nxt = m_pc + AW'(INC);
        end
        check({tag, "_cnt_next"}, 32'(bus.cnt_next), 32'(nxt));
        m_pc    = nxt;
        e.pc    = nxt;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.err   = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_cnt"},   32'(bus.cnt),       32'(e.pc));
            check({tag, "_empty"}, 32'(bus.stk_empty), 32'(e.empty));
            check({tag, "_full"},  32'(bus.stk_full),  32'(e.full));
            check({tag, "_err"},   32'(bus.stk_err),   32'(e.err));
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [AW-1:0] a);
        step(tag, 1'b0, 1'b1, a, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic call(input string tag, input logic [AW-1:0] a);
        step(tag, 1'b0, 1'b0, a, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic ret(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic branch(input string tag, input logic [OW-1:0] off);
        step(tag, 1'b0, 1'b0, '0, 1'b1, off, 1'b0, 1'b0);
    endtask

    // Assert reset between a rising and a falling edge, check it takes effect
    // without a clock, then release at the falling edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.stall   = 1'b0;
        bus.wrPC    = 1'b0;
        bus.dataIn  = '0;
        bus.br_en   = 1'b0;
        bus.br_off  = '0;
        bus.call_en = 1'b0;
        bus.ret_en  = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;

        // Reset: free-run, then reset mid-cycle and count up again.
        for (int i = 0; i < 3; i++) idle("run");
        async_reset("midcyc_rst");
        for (int i = 0; i < 4; i++) idle("count");

        // Priority: wrPC beats call and branch; stall beats everything.
        step("prio_load", 1'b0, 1'b1, 16'h0100, 1'b1, 8'h05, 1'b1, 1'b0);
        step("prio_stall", 1'b1, 1'b1, 16'h0200, 1'b1, 8'h05, 1'b1, 1'b1);
        step("stall_idle", 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        idle("after_stall");

        // Wrap-around and branches.
        load("ld_fffe", 16'hFFFE);
        idle("wrap1");
        idle("wrap2");
        load("ld_0010", 16'h0010);
        branch("br_back", 8'hF0);
        branch("br_spin", 8'h00);
        branch("br_fwd", 8'h7F);
        branch("br_min", 8'h80);

        // Call/return; in the stackless build, call loads and ret increments.
        load("ld_0020", 16'h0020);
        call("call_400", 16'h0400);
        step("stall_ret", 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1);
        ret("ret_0021");
        idle("after_ret");

        // Overflow, drain, underflow, then reset clears the sticky error.
        load("ld_1000", 16'h1000);
        for (int i = 0; i < DEPTH + 1; i++) call("nest", 16'(16'h2000 + i * 16));
        idle("spin_top");
        for (int i = 0; i < DEPTH; i++) ret("unwind");
        ret("ret_empty");
        idle("err_sticky");
        async_reset("rst_clears_err");

        // Reset with live stack entries discards them.
        call("pre_rst_call_a", 16'h0300);
        call("pre_rst_call_b", 16'h0380);
        async_reset("rst_mid_call");
        ret("ret_after_rst");
        idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the stimulus is a few hundred cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
